// File: rtl/rs_age_issue_scheduler.sv
// Age-matrix issue scheduler for the reservation station: picks up to WAYS ready
// entries per cycle, oldest first, and binds them densely to the non-busy ALU lanes.
module rs_age_issue_scheduler #(
  parameter int WAYS = 3,
  parameter int RS   = 16,
  localparam int IW  = $clog2(RS),
  localparam int LW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [RS-1:0]        alloc_en,
  input  logic [RS*LW-1:0]     alloc_lane,
  input  logic [RS-1:0]        ready,
  input  logic [WAYS-1:0]      fu_busy,
  input  logic                 flush,
  output logic [WAYS-1:0]      issue_valid,
  output logic [WAYS*IW-1:0]   issue_idx,
  output logic [RS-1:0]        issue_gnt,
  output logic [IW:0]          num_free,
  output logic                 alloc_err
);

  logic [RS-1:0] entry_valid;
  logic [RS-1:0] age     [RS];
  logic [RS-1:0] age_nxt [RS];
  logic [RS-1:0] cand;
  logic [RS-1:0] new_occ;
  logic [IW:0]   rank     [RS];
  logic [IW:0]   lane_ord [WAYS];
  logic [IW:0]   free_cnt;
  logic [IW:0]   num_free_nxt;
  logic [LW-1:0] lane_of  [RS];
  logic          dup_lane;
  logic          err_now;

  function automatic logic [IW:0] popcnt(input logic [RS-1:0] v);
    logic [IW:0] n;
    n = '0;
    for (int i = 0; i < RS; i++) n = n + (IW+1)'(v[i]);
    return n;
  endfunction

  // rank(i) = number of older candidates; it is the candidate's slot among the free lanes
  always_comb begin
    cand = entry_valid & ready & ~{RS{flush | reset}};
    for (int i = 0; i < RS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < RS; j++) rank[i] = rank[i] + (IW+1)'(cand[j] & age[j][i]);
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int k = 0; k < WAYS; k++) begin
      lane_ord[k] = free_cnt;
      if (!fu_busy[k]) free_cnt = free_cnt + 1'b1;
    end
  end

  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    issue_gnt   = '0;
    for (int i = 0; i < RS; i++)
      if (cand[i] && (rank[i] < free_cnt)) issue_gnt[i] = 1'b1;
    for (int k = 0; k < WAYS; k++) begin
      if (!fu_busy[k]) begin
        for (int i = 0; i < RS; i++) begin
          if (cand[i] && (rank[i] == lane_ord[k])) begin
            issue_valid[k]          = 1'b1;
            issue_idx[k*IW +: IW]   = IW'(i);
          end
        end
      end
    end
  end

  always_comb begin
    dup_lane = 1'b0;
    for (int i = 0; i < RS; i++) lane_of[i] = alloc_lane[i*LW +: LW];
    for (int i = 0; i < RS; i++)
      for (int j = i + 1; j < RS; j++)
        if (alloc_en[i] && alloc_en[j] && (lane_of[i] == lane_of[j])) dup_lane = 1'b1;
    err_now = dup_lane | (|(alloc_en & entry_valid));
  end

  // Re-allocating an entry that stays live does not consume a slot, so the count tracks occupancy
  always_comb begin
    new_occ      = alloc_en & ~(entry_valid & ~issue_gnt);
    num_free_nxt = num_free - popcnt(new_occ) + popcnt(issue_gnt);
  end

  always_comb begin
    age_nxt = age;
    for (int r = 0; r < RS; r++) begin
      for (int c = 0; c < RS; c++) begin
        if (r == c)              age_nxt[r][c] = 1'b0;
        else if (alloc_en[r])    age_nxt[r][c] = alloc_en[c] && (lane_of[r] < lane_of[c]);
        else if (alloc_en[c])    age_nxt[r][c] = entry_valid[r] && !issue_gnt[r];
        else if (issue_gnt[r] || issue_gnt[c]) age_nxt[r][c] = 1'b0;
        else                     age_nxt[r][c] = age[r][c];
      end
    end
  end

  // State update: flush empties everything but leaves the sticky error alone
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid <= '0;
      num_free    <= (IW+1)'(RS);
      alloc_err   <= 1'b0;
      for (int r = 0; r < RS; r++) age[r] <= '0;
    end else begin
      if (err_now) alloc_err <= 1'b1;
      if (flush) begin
        entry_valid <= '0;
        num_free    <= (IW+1)'(RS);
        for (int r = 0; r < RS; r++) age[r] <= '0;
      end else begin
        entry_valid <= (entry_valid & ~issue_gnt) | alloc_en;
        num_free    <= num_free_nxt;
        for (int r = 0; r < RS; r++) age[r] <= age_nxt[r];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (num_free == ((IW+1)'(RS) - popcnt(entry_valid)));
  end

endmodule

// File: tb/tb_rs_age_issue_scheduler.sv
// Bench for rs_age_issue_scheduler: directed scenarios plus randomized traffic
// checked against an allocation-timestamp reference model.
module tb_rs_age_issue_scheduler;
  localparam int WAYS = 3;
  localparam int RS   = 16;
  localparam int IW   = 4;
  localparam int LW   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [RS-1:0]       alloc_en;
  logic [RS*LW-1:0]    alloc_lane;
  logic [RS-1:0]       ready;
  logic [WAYS-1:0]     fu_busy;
  logic                flush;
  logic [WAYS-1:0]     issue_valid;
  logic [WAYS*IW-1:0]  issue_idx;
  logic [RS-1:0]       issue_gnt;
  logic [IW:0]         num_free;
  logic                alloc_err;

  int n_cmp = 0;
  int n_bad = 0;

  rs_age_issue_scheduler #(.WAYS(WAYS), .RS(RS)) dut (
    .clock(clock), .reset(reset), .alloc_en(alloc_en), .alloc_lane(alloc_lane),
    .ready(ready), .fu_busy(fu_busy), .flush(flush), .issue_valid(issue_valid),
    .issue_idx(issue_idx), .issue_gnt(issue_gnt), .num_free(num_free), .alloc_err(alloc_err)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic clr_in();
    alloc_en = '0; alloc_lane = '0; ready = '0; fu_busy = '0; flush = 1'b0;
  endtask

  task automatic put_alloc(input int e, input int lane);
    alloc_en[e] = 1'b1;
    alloc_lane[e*LW +: LW] = LW'(lane);
  endtask

  function automatic logic [IW-1:0] lane_idx(input int k);
    return issue_idx[k*IW +: IW];
  endfunction

  task automatic test_reset();
    reset = 1'b1; clr_in(); ready = '1;
    cyc(); cyc(); #1;
    n_cmp++; if (num_free !== 5'd16) begin n_bad++; $display("FAIL reset_num_free got %0d want 16", num_free); end
    n_cmp++; if (issue_valid !== 3'b000) begin n_bad++; $display("FAIL reset_issue_valid got %b want 000", issue_valid); end
    n_cmp++; if (issue_gnt !== 16'h0) begin n_bad++; $display("FAIL reset_issue_gnt got %h want 0000", issue_gnt); end
    n_cmp++; if (alloc_err !== 1'b0) begin n_bad++; $display("FAIL reset_alloc_err got %b want 0", alloc_err); end
    reset = 1'b0; clr_in();
    cyc();
  endtask

  task automatic test_age_order();
    clr_in(); put_alloc(9, 0); cyc();
    clr_in(); put_alloc(2, 0); cyc();
    clr_in(); put_alloc(5, 0); cyc();
    clr_in(); ready = 16'h0224; #1;
    n_cmp++; if (issue_valid !== 3'b111) begin n_bad++; $display("FAIL age_valid got %b want 111", issue_valid); end
    n_cmp++; if (lane_idx(0) !== 4'd9) begin n_bad++; $display("FAIL age_lane0 got %0d want 9", lane_idx(0)); end
    n_cmp++; if (lane_idx(1) !== 4'd2) begin n_bad++; $display("FAIL age_lane1 got %0d want 2", lane_idx(1)); end
    n_cmp++; if (lane_idx(2) !== 4'd5) begin n_bad++; $display("FAIL age_lane2 got %0d want 5", lane_idx(2)); end
    n_cmp++; if (issue_gnt !== 16'h0224) begin n_bad++; $display("FAIL age_gnt got %h want 0224", issue_gnt); end
    n_cmp++; if (num_free !== 5'd13) begin n_bad++; $display("FAIL age_num_free got %0d want 13", num_free); end
    cyc(); clr_in(); #1;
    n_cmp++; if (num_free !== 5'd16) begin n_bad++; $display("FAIL age_num_free_after got %0d want 16", num_free); end
    cyc();
  endtask

  task automatic test_busy_lane();
    clr_in(); put_alloc(7, 2); put_alloc(3, 0); put_alloc(4, 1); cyc();
    clr_in(); ready = 16'h0098; fu_busy = 3'b010; #1;
    n_cmp++; if (issue_valid !== 3'b101) begin n_bad++; $display("FAIL busy_valid got %b want 101", issue_valid); end
    n_cmp++; if (lane_idx(0) !== 4'd3) begin n_bad++; $display("FAIL busy_lane0 got %0d want 3", lane_idx(0)); end
    n_cmp++; if (lane_idx(2) !== 4'd4) begin n_bad++; $display("FAIL busy_lane2 got %0d want 4", lane_idx(2)); end
    n_cmp++; if (lane_idx(1) !== 4'd0) begin n_bad++; $display("FAIL busy_lane1_idx got %0d want 0", lane_idx(1)); end
    cyc();
    fu_busy = 3'b000; #1;
    n_cmp++; if (issue_valid !== 3'b001) begin n_bad++; $display("FAIL busy_retry_valid got %b want 001", issue_valid); end
    n_cmp++; if (lane_idx(0) !== 4'd7) begin n_bad++; $display("FAIL busy_retry_lane0 got %0d want 7", lane_idx(0)); end
    cyc(); clr_in(); #1;
    n_cmp++; if (num_free !== 5'd16) begin n_bad++; $display("FAIL busy_num_free got %0d want 16", num_free); end
    cyc();
  endtask

  task automatic test_starvation();
    clr_in(); put_alloc(15, 0); cyc();
    clr_in(); put_alloc(0, 0); put_alloc(1, 1); cyc();
    clr_in(); ready = 16'h0003; fu_busy = 3'b011; #1;
    n_cmp++; if (issue_valid !== 3'b100 || lane_idx(2) !== 4'd0) begin n_bad++; $display("FAIL starve_c2 got %b/%0d want 100/0", issue_valid, lane_idx(2)); end
    cyc();
    put_alloc(0, 0); #1;
    n_cmp++; if (issue_valid !== 3'b100 || lane_idx(2) !== 4'd1) begin n_bad++; $display("FAIL starve_c3 got %b/%0d want 100/1", issue_valid, lane_idx(2)); end
    cyc();
    alloc_en = '0; alloc_lane = '0; put_alloc(1, 0); #1;
    n_cmp++; if (issue_valid !== 3'b100 || lane_idx(2) !== 4'd0) begin n_bad++; $display("FAIL starve_c4 got %b/%0d want 100/0", issue_valid, lane_idx(2)); end
    cyc();
    alloc_en = '0; alloc_lane = '0; put_alloc(0, 0); ready = 16'h8003; #1;
    n_cmp++; if (issue_valid !== 3'b100) begin n_bad++; $display("FAIL starve_c5_valid got %b want 100", issue_valid); end
    n_cmp++; if (lane_idx(2) !== 4'd15) begin n_bad++; $display("FAIL starve_c5_lane2 got %0d want 15", lane_idx(2)); end
    cyc();
    clr_in(); flush = 1'b1; cyc();
    clr_in(); #1;
    n_cmp++; if (num_free !== 5'd16 || alloc_err !== 1'b0) begin n_bad++; $display("FAIL starve_end got %0d/%b want 16/0", num_free, alloc_err); end
  endtask

  task automatic test_flush();
    clr_in(); put_alloc(8, 0); cyc();
    clr_in(); flush = 1'b1; put_alloc(6, 0); ready = 16'h0100; #1;
    n_cmp++; if (issue_valid !== 3'b000) begin n_bad++; $display("FAIL flush_valid got %b want 000", issue_valid); end
    n_cmp++; if (issue_gnt !== 16'h0) begin n_bad++; $display("FAIL flush_gnt got %h want 0000", issue_gnt); end
    cyc();
    clr_in(); ready = 16'h0140; #1;
    n_cmp++; if (num_free !== 5'd16) begin n_bad++; $display("FAIL flush_num_free got %0d want 16", num_free); end
    n_cmp++; if (issue_valid !== 3'b000) begin n_bad++; $display("FAIL flush_entry6 got %b want 000", issue_valid); end
    cyc(); clr_in();
  endtask

  task automatic test_random();
    bit        mvalid [RS];
    longint    mkey   [RS];
    longint    tick_n;
    logic [WAYS-1:0]    exp_v;
    logic [WAYS*IW-1:0] exp_idx;
    logic [RS-1:0]      exp_g;
    int        exp_free;
    reset = 1'b1; clr_in(); cyc(); reset = 1'b0; cyc();
    for (int i = 0; i < RS; i++) begin mvalid[i] = 1'b0; mkey[i] = 0; end
    tick_n = 0;
    for (int t = 0; t < 400; t++) begin
      bit   taken [RS];
      int   fq[$];
      int   lp [WAYS];
      int   n_al, best, pick, tmp;
      clr_in();
      flush      = ($urandom_range(0, 39) == 0);
      ready      = 16'($urandom);
      fu_busy    = 3'($urandom_range(0, 7));
      alloc_lane = $urandom;
      for (int i = 0; i < RS; i++) if (!mvalid[i]) fq.push_back(i);
      for (int k = 0; k < WAYS; k++) lp[k] = k;
      for (int k = WAYS - 1; k > 0; k--) begin
        pick = $urandom_range(0, k); tmp = lp[k]; lp[k] = lp[pick]; lp[pick] = tmp;
      end
      n_al = $urandom_range(0, (fq.size() < WAYS) ? fq.size() : WAYS);
      for (int a = 0; a < n_al; a++) begin
        pick = $urandom_range(0, fq.size() - 1);
        put_alloc(fq[pick], lp[a]);
        fq.delete(pick);
      end
      exp_v = '0; exp_idx = '0; exp_g = '0; exp_free = 0;
      for (int i = 0; i < RS; i++) begin taken[i] = 1'b0; if (!mvalid[i]) exp_free++; end
      for (int k = 0; k < WAYS; k++) begin
        if (!fu_busy[k]) begin
          best = -1;
          for (int i = 0; i < RS; i++)
            if (mvalid[i] && ready[i] && !flush && !taken[i] && (best < 0 || mkey[i] < mkey[best])) best = i;
          if (best >= 0) begin
            taken[best] = 1'b1; exp_v[k] = 1'b1; exp_idx[k*IW +: IW] = IW'(best); exp_g[best] = 1'b1;
          end
        end
      end
      #1;
      n_cmp++; if (issue_valid !== exp_v) begin n_bad++; $display("FAIL rnd_valid t=%0d got %b want %b", t, issue_valid, exp_v); end
      n_cmp++; if (issue_idx !== exp_idx) begin n_bad++; $display("FAIL rnd_idx t=%0d got %h want %h", t, issue_idx, exp_idx); end
      n_cmp++; if (issue_gnt !== exp_g) begin n_bad++; $display("FAIL rnd_gnt t=%0d got %h want %h", t, issue_gnt, exp_g); end
      n_cmp++; if (num_free !== 5'(exp_free)) begin n_bad++; $display("FAIL rnd_num_free t=%0d got %0d want %0d", t, num_free, exp_free); end
      n_cmp++; if (alloc_err !== 1'b0) begin n_bad++; $display("FAIL rnd_alloc_err t=%0d got %b want 0", t, alloc_err); end
      cyc();
      for (int i = 0; i < RS; i++) begin
        if (flush) mvalid[i] = 1'b0;
        else if (alloc_en[i]) begin
          mvalid[i] = 1'b1;
          mkey[i]   = tick_n * WAYS + longint'(alloc_lane[i*LW +: LW]);
        end else if (exp_g[i]) mvalid[i] = 1'b0;
      end
      tick_n++;
    end
    clr_in();
  endtask

  task automatic test_error();
    reset = 1'b1; clr_in(); cyc(); reset = 1'b0; cyc();
    put_alloc(4, 0); cyc();
    clr_in(); put_alloc(4, 0); #1;
    n_cmp++; if (alloc_err !== 1'b0) begin n_bad++; $display("FAIL err_early got %b want 0", alloc_err); end
    cyc(); clr_in(); #1;
    n_cmp++; if (alloc_err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", alloc_err); end
    n_cmp++; if (num_free !== 5'd15) begin n_bad++; $display("FAIL err_num_free got %0d want 15", num_free); end
    flush = 1'b1; cyc(); clr_in(); cyc(); cyc(); #1;
    n_cmp++; if (alloc_err !== 1'b1) begin n_bad++; $display("FAIL err_held got %b want 1", alloc_err); end
    reset = 1'b1; cyc(); reset = 1'b0; #1;
    n_cmp++; if (alloc_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", alloc_err); end
    put_alloc(2, 1); put_alloc(3, 1); cyc();
    clr_in(); #1;
    n_cmp++; if (alloc_err !== 1'b1) begin n_bad++; $display("FAIL err_dup_lane got %b want 1", alloc_err); end
    n_cmp++; if (num_free !== 5'd14) begin n_bad++; $display("FAIL err_dup_num_free got %0d want 14", num_free); end
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_age_order();
    test_busy_lane();
    test_starvation();
    test_flush();
    test_random();
    test_error();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
